// File: rtl/ps2_mouse_rx_if.sv
// ps2_mouse_rx_if
// Groups the PS/2 pad lines and the Kempston-facing mouse bus.
//   ps2_clk, ps2_data : raw PS/2 lines from the pad (asynchronous)
//   ps2_mouse         : {left button, Y counter, X counter}
//   ps2_mouse_new     : one-cycle strobe when ps2_mouse takes a new packet
//   frame_err         : one-cycle strobe on any discarded byte
//   rx_state          : current frame FSM state (debug)
// master = the receiver, slave = the consumer / pad model.
interface ps2_mouse_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [16:0] ps2_mouse;
  logic        ps2_mouse_new;
  logic        frame_err;
  logic [1:0]  rx_state;

  modport master (
    input  ps2_clk, ps2_data,
    output ps2_mouse, ps2_mouse_new, frame_err, rx_state
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  ps2_mouse, ps2_mouse_new, frame_err, rx_state
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
// Deserialises PS/2 device-to-host frames, assembles 3-byte stream-mode mouse
// packets and accumulates the X/Y deltas into 8-bit wrap-around counters.
// Ports:
//   clk_sys : system clock (only clock)
//   reset_n : asynchronous active-low reset
//   bus     : ps2_mouse_rx_if.master (pad lines in, mouse bus + strobes out)
// Handshake: ps2_mouse_new is a single-cycle valid with no ready; ps2_mouse is
// registered and holds its value until the next packet, so a consumer may
// sample it at any time and use the strobe only to detect change.
module ps2_mouse_rx #(
  parameter int          FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd40000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  ps2_mouse_rx_if.master  bus
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILTER - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic [15:0]   to_cnt;
  logic [1:0]    idx;
  logic [7:0]    b0, b1;
  logic [7:0]    pos_x, pos_y;
  logic          btn;
  logic          mouse_new;
  logic          err;
  logic          sample;

  assign sample = filt[1];

  // Synchroniser + stability filter. A line's filtered value only follows the
  // synchronised value after FILTER consecutive cycles of disagreement, so any
  // shorter glitch restarts the count. The clock-fall event is registered in
  // the same edge that the filtered clock drops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= {bus.ps2_data, bus.ps2_clk};
      sync2 <= sync1;
      fall  <= filt[0] && !sync2[0] && (fcnt[0] == FMAX);
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Frame FSM, timeout and packet assembler. The third byte is still in
  // shift when its stop bit arrives, so the counters update on that edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      idx       <= '0;
      b0        <= '0;
      b1        <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      btn       <= 1'b0;
      mouse_new <= 1'b0;
      err       <= 1'b0;
    end else begin
      mouse_new <= 1'b0;
      err       <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!sample) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              err <= 1'b1;
              idx <= '0;
            end
          end
          DATA: begin
            shift   <= {sample, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shift, sample};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (par_ok && sample) begin
              case (idx)
                2'd0: begin
                  // Resync: a first byte without bit 3 set is dropped silently.
                  if (shift[3]) begin
                    b0  <= shift;
                    idx <= 2'd1;
                  end
                end
                2'd1: begin
                  b1  <= shift;
                  idx <= 2'd2;
                end
                default: begin
                  // Low byte of the 9-bit delta is the payload byte itself.
                  pos_x     <= pos_x + (b0[6] ? 8'd0 : b1);
                  pos_y     <= pos_y + (b0[7] ? 8'd0 : shift);
                  btn       <= b0[0];
                  mouse_new <= 1'b1;
                  idx       <= 2'd0;
                end
              endcase
            end else begin
              err <= 1'b1;
              idx <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TIMEOUT) begin
          state  <= IDLE;
          err    <= 1'b1;
          idx    <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign bus.ps2_mouse     = {btn, pos_y, pos_x};
  assign bus.ps2_mouse_new = mouse_new;
  assign bus.frame_err     = err;
  assign bus.rx_state      = state;

endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

Receives the raw PS/2 mouse serial stream, deserialises 11-bit device-to-host frames, and assembles standard 3-byte movement packets. It accumulates the signed X/Y deltas into 8-bit wrap-around absolute counters and presents them, with the left button, on the 17-bit `ps2_mouse` bus consumed by the Kempston mouse port decoder. The mouse is already in stream mode; this block never drives the PS/2 lines.

## Interface

- `FILTER`, default 8: number of consecutive `clk_sys` cycles a synchronised PS/2 line must hold a new level before it is accepted.
- `TIMEOUT`, default 16'd40000: `clk_sys` cycles without a filtered `ps2_clk` falling edge before a partial frame is aborted. This is about 2 ms at 20 MHz.
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pad; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pad; asynchronous.
- `ps2_mouse`  out  17  bit [16] = left button (1 = pressed), bits [15:8] = Y counter, bits [7:0] = X counter.
- `ps2_mouse_new`  out  1  one-cycle strobe, asserted in the cycle `ps2_mouse` takes a new packet's values.
- `frame_err`  out  1  one-cycle strobe on any discarded byte: start, parity, stop or timeout error.

## Operation

- Input conditioning:
  - Each line passes through a 2-flop synchroniser, then the `FILTER` stability filter.
  - A falling edge of the filtered `ps2_clk` is the sample event; `ps2_data` is sampled at that event.
- Frame FSM states:
  - IDLE: the sample must be 0 (start bit), then go to DATA; a 1 raises `frame_err` and the FSM stays in IDLE.
  - DATA: 8 samples shifted in LSB first, bit count 0..7; after the 8th sample go to PARITY.
  - PARITY: the sample must make the 9-bit total (data + parity) odd; go to STOP.
  - STOP: the sample must be 1. If parity and stop are both good, the byte is valid; otherwise raise `frame_err`. Return to IDLE either way.
- Timeout: in any state other than IDLE, a count reaching `TIMEOUT` with no sample event aborts to IDLE, raises `frame_err` and resets the packet index to 0.
- Packet assembler:
  - Index runs 0, 1, 2.
  - Byte 0 is accepted only if bit 3 = 1. Otherwise it is discarded, the index stays at 0 and no `frame_err` is raised; this is the resync rule.
  - Any `frame_err` resets the index to 0.
- On a valid byte 2:
  - dx = {b0[4], b1}, dy = {b0[5], b2}, both 9-bit two's complement.
  - If overflow flag b0[6] is set, dx is treated as 0; if b0[7] is set, dy is treated as 0.
  - X <= X + dx[7:0] mod 256; Y <= Y + dy[7:0] mod 256. Positive Y means upward motion.
  - Button <= b0[0].
  - `ps2_mouse_new` = 1 for that cycle.

## Timing

- Reset values: `ps2_mouse` = 17'h0, `ps2_mouse_new` = 0, `frame_err` = 0, FSM = IDLE, index = 0, filters = 1 (bus idle high).
- Latency: a raw `ps2_clk` fall that is held stable produces its sample event 2 + `FILTER` cycles later.
- Output update: the byte-2 stop-bit sample event updates `ps2_mouse` and pulses `ps2_mouse_new` on the next `clk_sys` edge. `ps2_mouse` then holds until the next packet.
- Glitches shorter than `FILTER` cycles on either line are ignored.
- Reset asserted mid-frame or mid-packet clears everything immediately. After release, the FSM waits in IDLE for a new start bit.
- `frame_err` and `ps2_mouse_new` are never asserted in the same cycle.

## Test plan

- Packet 08,05,03 from reset -> X = 05, Y = 03, button = 0, exactly one `ps2_mouse_new` pulse, `frame_err` never asserted.
- Packet 39,FE,FF (left button, dx = -2, dy = -1) after reset -> X = FE, Y = FF, `ps2_mouse[16]` = 1.
- Packets 08,F0,00 then 08,20,00 -> X = F0, then 10 (wrap-around); Y stays 00.
- Byte 1 sent with a wrong parity bit -> `frame_err` pulses once, X/Y unchanged. The next clean packet 08,01,01 gives X = 01, Y = 01.
- Stream 05 then 08,02,02 (bad bit 3 on the first byte) -> 05 is dropped silently and the packet is decoded: X = 02, Y = 02. Separately, a frame stalled after 4 data bits for `TIMEOUT` cycles -> `frame_err` pulses and the next full packet decodes correctly.
- Packet 48,80,04 (X overflow) -> X unchanged, Y += 4. Then `reset_n` pulsed low mid-byte -> all outputs 0 within the same cycle.
